hard_mem_1rw_req_driver: RTL and testbench
==========================================

Name: hard_mem_1rw_req_driver

Overview:
- Initiator-side controller for the 1rw hard-memory wrappers (bit/byte-mask, d512 w64 class).
- Accepts a valid/ready request stream from core logic and drives the wrapper pins (v, w, addr, data, write mask).
- Absorbs the macro's 1-cycle read latency and returns read data on a valid/yumi response stream through a small credit-managed buffer.
- Zero-fills the whole array after reset so downstream tags and state arrays start from a known state.

Parameters:
- width_p, 64, data width in bits.
- els_p, 512, number of memory words.
- addr_width_lp, $clog2(els_p), address width (derived).
- write_mask_width_lp, width_p>>3, byte write-mask width (derived).
- resp_els_p, 3, response buffer depth; legal range is 2 or more; 3 gives full read throughput.

Ports:
- clk_i  in  1  the single clock.
- reset_i  in  1  synchronous, active-high reset.
- req_v_i  in  1  request valid.
- req_ready_o  out  1  request ready; a transfer occurs when req_v_i & req_ready_o.
- req_w_i  in  1  1 = write, 0 = read.
- req_addr_i  in  addr_width_lp  word address.
- req_data_i  in  width_p  write data.
- req_write_mask_i  in  write_mask_width_lp  byte enables; 1 = write that byte.
- resp_v_o  out  1  response valid.
- resp_data_o  out  width_p  read data.
- resp_yumi_i  in  1  consumer takes the response; legal only while resp_v_o = 1.
- mem_v_o  out  1  to wrapper v_i.
- mem_w_o  out  1  to wrapper w_i.
- mem_addr_o  out  addr_width_lp  to wrapper addr_i.
- mem_data_o  out  width_p  to wrapper data_i.
- mem_write_mask_o  out  write_mask_width_lp  to wrapper write_mask_i.
- mem_data_i  in  width_p  from wrapper data_o; valid the cycle after a read is issued.

Behaviour:
- The clock is clk_i. Reset is synchronous and active-high on reset_i; all state clears on the edge where reset_i = 1.
- Values while reset_i is high and immediately after it drops:
  - state = INIT, init_cnt = 0.
  - Buffer is empty; the inflight flag is 0.
  - req_ready_o = 0, resp_v_o = 0.
  - mem_v_o = 0 while reset_i = 1.
- State INIT:
  - Every cycle drives mem_v_o = 1, mem_w_o = 1, mem_addr_o = init_cnt, mem_data_o = 0, mem_write_mask_o = all ones.
  - init_cnt increments each cycle.
  - After the cycle that writes address els_p-1, the next state is RUN.
  - INIT lasts exactly els_p cycles (512 by default). req_ready_o = 0 throughout.
- State RUN:
  - req_ready_o = (buf_count + inflight) < resp_els_p.
  - Pin drive is combinational from the request:
    - mem_v_o = req_v_i & req_ready_o.
    - mem_w_o = req_w_i.
    - mem_addr_o, mem_data_o and mem_write_mask_o pass the request fields straight through.
  - When mem_v_o = 0, mem_w_o = 0 and the other mem pins are don't-care.
- Read flow:
  - An accepted read in cycle t sets inflight = 1 at the end of cycle t.
  - In cycle t+1, mem_data_i is enqueued; inflight clears unless a new read is issued that same cycle.
  - resp_v_o = 1 from cycle t+2. Fixed read latency is 2 cycles, request accept to response valid.
- Writes:
  - No response is produced.
  - A write consumes no credit but still requires req_ready_o = 1.
- Response buffer:
  - FIFO of depth resp_els_p; responses return in request order.
  - Enqueue and dequeue in the same cycle leave buf_count unchanged.
  - Overflow cannot occur by construction. An overflow is an assertion failure.
- resp_yumi_i while resp_v_o = 0 is illegal and is asserted against. The design ignores it.
- Full throughput: with resp_els_p = 3 and resp_yumi_i held at 1, back-to-back reads sustain 1 read per cycle.
- Reset in RUN drops all buffered and inflight responses and restarts INIT from address 0.
- Reset in INIT restarts the sweep from address 0.
- req_ready_o does not depend on req_v_i or resp_yumi_i.

Optional Feature:
- Macro: HARD_MEM_REQ_DRIVER_WRITE_ACK_EN.
- When defined:
  - Every accepted write also produces a response with resp_data_o = 0, ordered with the reads.
  - Writes consume a credit exactly like reads, using the same inflight/buffer path, with 2-cycle latency.
- When undefined: writes produce no response, as described in Behaviour.

Test Plan:
- Reset, then idle: req_ready_o = 0 for exactly 512 cycles, with mem_v_o = mem_w_o = 1 and mem_addr_o sweeping 0..511 and data 0. Ready rises in cycle 513. A read of addr 37 then returns 0.
- Write addr 5 = 0x0123456789ABCDEF with mask 0xFF, then a read of addr 5: resp_v_o asserts 2 cycles after the read is accepted, with data 0x0123456789ABCDEF.
- Byte mask: write addr 9 = all-ones with mask 0x0F, then read addr 9 -> 0x00000000FFFFFFFF.
- Backpressure: resp_yumi_i = 0 and a stream of reads -> exactly 3 reads accepted, then req_ready_o = 0. Releasing yumi drains the 3 in order, and ready reasserts the cycle after the first dequeue.
- Throughput: 100 back-to-back reads with resp_yumi_i tied to resp_v_o -> 100 responses in 101 cycles after the first, in order.
- Reset mid-RUN with 2 responses buffered: resp_v_o = 0 the next cycle, no stale response appears, and INIT restarts at address 0.
- With HARD_MEM_REQ_DRIVER_WRITE_ACK_EN: a write followed by a read yields two responses, 0 then the read data.

Source files
------------

// File: rtl/hard_mem_1rw_req_driver.sv
// Initiator-side driver for 1rw hard-memory wrappers: zero-fills the array after reset,
// then forwards requests and returns reads. Optional macro HARD_MEM_REQ_DRIVER_WRITE_ACK_EN.
module hard_mem_1rw_req_driver #(
    parameter  int unsigned width_p             = 64,
    parameter  int unsigned els_p               = 512,
    parameter  int unsigned resp_els_p          = 3,
    localparam int unsigned addr_width_lp       = $clog2(els_p),
    localparam int unsigned write_mask_width_lp = width_p >> 3
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           req_v_i,
    output logic                           req_ready_o,
    input  logic                           req_w_i,
    input  logic [addr_width_lp-1:0]       req_addr_i,
    input  logic [width_p-1:0]             req_data_i,
    input  logic [write_mask_width_lp-1:0] req_write_mask_i,
    output logic                           resp_v_o,
    output logic [width_p-1:0]             resp_data_o,
    input  logic                           resp_yumi_i,
    output logic                           mem_v_o,
    output logic                           mem_w_o,
    output logic [addr_width_lp-1:0]       mem_addr_o,
    output logic [width_p-1:0]             mem_data_o,
    output logic [write_mask_width_lp-1:0] mem_write_mask_o,
    input  logic [width_p-1:0]             mem_data_i
);

    localparam int unsigned ptr_w_lp = (resp_els_p > 1) ? $clog2(resp_els_p) : 1;
    localparam int unsigned cnt_w_lp = $clog2(resp_els_p + 1);

    typedef enum logic [0:0] {ST_INIT, ST_RUN} state_e;

    state_e                     state_q, state_d;
    logic [addr_width_lp-1:0]   init_cnt_q;
    logic                       init_last;
    logic                       inflight_q;
    logic                       credit_ok;
    logic                       issue;
    logic                       enq, deq;
    logic [width_p-1:0]         enq_data;
    logic [width_p-1:0]         buf_q [resp_els_p];
    logic [ptr_w_lp-1:0]        wr_ptr_q, rd_ptr_q;
    logic [cnt_w_lp-1:0]        count_q;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(resp_els_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    assign init_last = (init_cnt_q == addr_width_lp'(els_p - 1));
    // Credits cover both buffered entries and the response still in the macro pipeline.
    assign credit_ok = ((cnt_w_lp + 1)'(count_q) + (cnt_w_lp + 1)'(inflight_q))
                       < (cnt_w_lp + 1)'(resp_els_p);

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= ST_INIT;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && init_last) state_d = ST_RUN;
    end

    always_comb begin
        req_ready_o      = 1'b0;
        mem_v_o          = 1'b0;
        mem_w_o          = 1'b0;
        mem_addr_o       = '0;
        mem_data_o       = '0;
        mem_write_mask_o = '0;
        if (!reset_i) begin
            case (state_q)
                ST_INIT: begin
                    mem_v_o          = 1'b1;
                    mem_w_o          = 1'b1;
                    mem_addr_o       = init_cnt_q;
                    mem_write_mask_o = '1;
                end
                default: begin
                    req_ready_o      = credit_ok;
                    mem_v_o          = req_v_i & credit_ok;
                    mem_w_o          = req_v_i & credit_ok & req_w_i;
                    mem_addr_o       = req_addr_i;
                    mem_data_o       = req_data_i;
                    mem_write_mask_o = req_write_mask_i;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)                 init_cnt_q <= '0;
        else if (state_q == ST_INIT) init_cnt_q <= init_cnt_q + addr_width_lp'(1);
    end

`ifdef HARD_MEM_REQ_DRIVER_WRITE_ACK_EN
    logic inflight_w_q;
    assign issue    = (state_q == ST_RUN) & mem_v_o;
    assign enq_data = inflight_w_q ? '0 : mem_data_i;
    always_ff @(posedge clk_i) begin
        if (reset_i) inflight_w_q <= 1'b0;
        else         inflight_w_q <= mem_w_o;
    end
`else
    assign issue    = (state_q == ST_RUN) & mem_v_o & ~mem_w_o;
    assign enq_data = mem_data_i;
`endif

    assign enq = inflight_q;
    assign deq = resp_yumi_i & resp_v_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) inflight_q <= 1'b0;
        else         inflight_q <= issue;
    end

    // Response FIFO; data storage needs no reset since count gates visibility.
    always_ff @(posedge clk_i) begin
        if (enq) buf_q[wr_ptr_q] <= enq_data;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (enq) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (deq) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({enq, deq})
                2'b10:   count_q <= count_q + cnt_w_lp'(1);
                2'b01:   count_q <= count_q - cnt_w_lp'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign resp_v_o    = (count_q != '0);
    assign resp_data_o = buf_q[rd_ptr_q];

    a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
        !(enq && !deq && count_q == cnt_w_lp'(resp_els_p)));
    a_yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i)
        !(resp_yumi_i && !resp_v_o));

endmodule

// File: tb/tb_hard_mem_1rw_req_driver.sv
// Directed self-checking bench for hard_mem_1rw_req_driver with a behavioural 1rw memory.
module tb_hard_mem_1rw_req_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_v, req_ready, req_w;
    logic [8:0]  req_addr;
    logic [63:0] req_data;
    logic [7:0]  req_mask;
    logic        resp_v, resp_yumi;
    logic [63:0] resp_data;
    logic        mem_v, mem_w;
    logic [8:0]  mem_addr;
    logic [63:0] mem_wdata, mem_rdata;
    logic [7:0]  mem_mask;
    logic        auto_drain, yumi_man;
    logic [63:0] mem_model [512];
    int          n_checks, n_fail;

    always #5 clk = ~clk;

    assign resp_yumi = auto_drain ? resp_v : yumi_man;

    hard_mem_1rw_req_driver dut (
        .clk_i(clk), .reset_i(reset),
        .req_v_i(req_v), .req_ready_o(req_ready), .req_w_i(req_w),
        .req_addr_i(req_addr), .req_data_i(req_data), .req_write_mask_i(req_mask),
        .resp_v_o(resp_v), .resp_data_o(resp_data), .resp_yumi_i(resp_yumi),
        .mem_v_o(mem_v), .mem_w_o(mem_w), .mem_addr_o(mem_addr),
        .mem_data_o(mem_wdata), .mem_write_mask_o(mem_mask), .mem_data_i(mem_rdata)
    );

    // Macro model: byte-masked write, read data valid the cycle after issue.
    always @(posedge clk) begin
        if (mem_v) begin
            if (mem_w) begin
                for (int b = 0; b < 8; b++)
                    if (mem_mask[b]) mem_model[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= mem_model[mem_addr];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic w, input logic [8:0] a, input logic [63:0] d,
                             input logic [7:0] m, output bit ok);
        ok = 1'b0;
        req_v = 1'b1; req_w = w; req_addr = a; req_data = d; req_mask = m;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (req_ready) ok = 1'b1;
            step();
        end
        req_v = 1'b0;
        #1;
    endtask

    task automatic settle_drain(input int cycles);
        auto_drain = 1'b1;
        for (int i = 0; i < cycles; i++) step();
        auto_drain = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step(); step();
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        n_checks++; if (resp_v !== 1'b0) begin n_fail++; $display("FAIL reset_resp_v: got %b want 0", resp_v); end
        n_checks++; if (mem_v !== 1'b0) begin n_fail++; $display("FAIL reset_mem_v: got %b want 0", mem_v); end
        reset = 1'b0;
        #1;
        for (int i = 0; i < 512; i++) begin
            n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL init_ready[%0d]: got %b want 0", i, req_ready); end
            n_checks++; if ({mem_v, mem_w} !== 2'b11) begin n_fail++; $display("FAIL init_vw[%0d]: got %b want 11", i, {mem_v, mem_w}); end
            n_checks++; if (mem_addr !== 9'(i)) begin n_fail++; $display("FAIL init_addr[%0d]: got %0d want %0d", i, mem_addr, i); end
            n_checks++; if (mem_wdata !== 64'h0 || mem_mask !== 8'hFF) begin n_fail++; $display("FAIL init_data[%0d]: got %h/%h want 0/ff", i, mem_wdata, mem_mask); end
            step();
        end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_init: got %b want 1", req_ready); end
    endtask

    task automatic test_zero_read();
        bit ok;
        drive_req(1'b0, 9'd37, 64'h0, 8'h0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL read37_accept: got 0 want 1"); end
        n_checks++; if (resp_v !== 1'b0) begin n_fail++; $display("FAIL read37_early: got %b want 0", resp_v); end
        step();
        n_checks++; if (resp_v !== 1'b1 || resp_data !== 64'h0) begin n_fail++; $display("FAIL read37_data: got %b/%h want 1/0", resp_v, resp_data); end
        yumi_man = 1'b1; step(); yumi_man = 1'b0; #1;
        n_checks++; if (resp_v !== 1'b0) begin n_fail++; $display("FAIL read37_pop: got %b want 0", resp_v); end
    endtask

    task automatic test_write_read();
        bit ok;
        drive_req(1'b1, 9'd5, 64'h0123456789ABCDEF, 8'hFF, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL wr5_accept: got 0 want 1"); end
        n_checks++; if (resp_v !== 1'b0) begin n_fail++; $display("FAIL wr5_t1: got %b want 0", resp_v); end
        step();
`ifdef HARD_MEM_REQ_DRIVER_WRITE_ACK_EN
        n_checks++; if (resp_v !== 1'b1 || resp_data !== 64'h0) begin n_fail++; $display("FAIL wr5_ack: got %b/%h want 1/0", resp_v, resp_data); end
        yumi_man = 1'b1; step(); yumi_man = 1'b0; #1;
`else
        n_checks++; if (resp_v !== 1'b0) begin n_fail++; $display("FAIL wr5_noresp: got %b want 0", resp_v); end
`endif
        drive_req(1'b0, 9'd5, 64'h0, 8'h0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rd5_accept: got 0 want 1"); end
        n_checks++; if (resp_v !== 1'b0) begin n_fail++; $display("FAIL rd5_early: got %b want 0", resp_v); end
        step();
        n_checks++; if (resp_v !== 1'b1 || resp_data !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL rd5_data: got %b/%h want 1/0123456789abcdef", resp_v, resp_data); end
        yumi_man = 1'b1; step(); yumi_man = 1'b0; #1;
    endtask

    task automatic test_byte_mask();
        bit ok;
        auto_drain = 1'b1;
        drive_req(1'b1, 9'd9, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, ok);
        settle_drain(3);
        drive_req(1'b0, 9'd9, 64'h0, 8'h0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rd9_accept: got 0 want 1"); end
        step();
        n_checks++; if (resp_v !== 1'b1 || resp_data !== 64'h0000_0000_FFFF_FFFF) begin n_fail++; $display("FAIL rd9_mask: got %b/%h want 1/00000000ffffffff", resp_v, resp_data); end
        yumi_man = 1'b1; step(); yumi_man = 1'b0; #1;
    endtask

    task automatic test_backpressure();
        bit          ok;
        int          acc;
        logic [63:0] v [3];
        auto_drain = 1'b1;
        for (int k = 0; k < 3; k++) begin
            v[k] = 64'hB000_0000_0000_0000 + 64'(k) * 64'h1111;
            drive_req(1'b1, 9'(20 + k), v[k], 8'hFF, ok);
        end
        settle_drain(3);
        acc = 0;
        req_v = 1'b1; req_w = 1'b0;
        for (int c = 0; c < 6; c++) begin
            req_addr = 9'(20 + acc);
            #1;
            if (req_ready) acc++;
            step();
        end
        #1;
        n_checks++; if (acc != 3) begin n_fail++; $display("FAIL bp_accepted: got %0d want 3", acc); end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b want 0", req_ready); end
        req_v = 1'b0;
        #1;
        n_checks++; if (resp_v !== 1'b1 || resp_data !== v[0]) begin n_fail++; $display("FAIL bp_head: got %b/%h want 1/%h", resp_v, resp_data, v[0]); end
        yumi_man = 1'b1; step();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %b want 1", req_ready); end
        n_checks++; if (resp_data !== v[1]) begin n_fail++; $display("FAIL bp_second: got %h want %h", resp_data, v[1]); end
        step();
        n_checks++; if (resp_data !== v[2]) begin n_fail++; $display("FAIL bp_third: got %h want %h", resp_data, v[2]); end
        step(); yumi_man = 1'b0; #1;
        n_checks++; if (resp_v !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b want 0", resp_v); end
    endtask

    task automatic test_throughput();
        bit ok;
        int sent, recv, first_acc, last_acc, last_resp;
        for (int i = 0; i < 100; i++)
            drive_req(1'b1, 9'(100 + i), {32'hC0DE_0000, 32'(i * 7)}, 8'hFF, ok);
        settle_drain(4);
        auto_drain = 1'b1;
        sent = 0; recv = 0; first_acc = -1; last_acc = -1; last_resp = -1;
        req_w = 1'b0;
        for (int c = 0; c < 300 && recv < 100; c++) begin
            req_v = (sent < 100);
            req_addr = 9'(100 + sent);
            #1;
            if (req_v && req_ready) begin
                if (first_acc < 0) first_acc = c;
                last_acc = c;
                sent++;
            end
            if (resp_v) begin
                n_checks++; if (resp_data !== {32'hC0DE_0000, 32'(recv * 7)}) begin n_fail++; $display("FAIL tp_data[%0d]: got %h want %h", recv, resp_data, {32'hC0DE_0000, 32'(recv * 7)}); end
                recv++;
                last_resp = c;
            end
            step();
        end
        req_v = 1'b0;
        auto_drain = 1'b0;
        #1;
        n_checks++; if (recv != 100) begin n_fail++; $display("FAIL tp_count: got %0d want 100", recv); end
        n_checks++; if (last_acc - first_acc != 99) begin n_fail++; $display("FAIL tp_accept_span: got %0d want 99", last_acc - first_acc); end
        n_checks++; if (last_resp - first_acc != 101) begin n_fail++; $display("FAIL tp_resp_span: got %0d want 101", last_resp - first_acc); end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        drive_req(1'b0, 9'd5, 64'h0, 8'h0, ok);
        drive_req(1'b0, 9'd9, 64'h0, 8'h0, ok);
        step();
        n_checks++; if (resp_v !== 1'b1) begin n_fail++; $display("FAIL mid_pre_buffered: got %b want 1", resp_v); end
        reset = 1'b1;
        step();
        n_checks++; if (resp_v !== 1'b0) begin n_fail++; $display("FAIL mid_resp_cleared: got %b want 0", resp_v); end
        n_checks++; if (mem_v !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_in_reset: got v=%b rdy=%b want 0/0", mem_v, req_ready); end
        reset = 1'b0;
        #1;
        for (int i = 0; i < 512; i++) begin
            n_checks++; if (resp_v !== 1'b0) begin n_fail++; $display("FAIL mid_stale[%0d]: got %b want 0", i, resp_v); end
            n_checks++; if (mem_v !== 1'b1 || mem_addr !== 9'(i)) begin n_fail++; $display("FAIL mid_sweep[%0d]: got v=%b addr=%0d want 1/%0d", i, mem_v, mem_addr, i); end
            step();
        end
        n_checks++; if (req_ready !== 1'b1 || resp_v !== 1'b0) begin n_fail++; $display("FAIL mid_run_again: got rdy=%b v=%b want 1/0", req_ready, resp_v); end
        drive_req(1'b0, 9'd5, 64'h0, 8'h0, ok);
        step();
        n_checks++; if (resp_v !== 1'b1 || resp_data !== 64'h0) begin n_fail++; $display("FAIL mid_rezeroed: got %b/%h want 1/0", resp_v, resp_data); end
        yumi_man = 1'b1; step(); yumi_man = 1'b0; #1;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem_model[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
        mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        n_checks = 0; n_fail = 0;
        reset = 1'b1; req_v = 1'b0; req_w = 1'b0; req_addr = '0; req_data = '0; req_mask = '0;
        auto_drain = 1'b0; yumi_man = 1'b0;
        test_reset();
        test_zero_read();
        test_write_read();
        test_byte_mask();
        test_backpressure();
        test_throughput();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
